// File: rtl/soc_msp430_dma_pkg.sv
// Shared types and constants for the DMEM port-B copy/fill engine.
package soc_msp430_dma_pkg;

    localparam int DMA_ADDR_W = 11;
    localparam int DMA_CNT_W  = 11;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } dma_state_t;

endpackage

// File: rtl/soc_msp430_dmem_dma.sv
// Word copy/fill engine on DMEM port B; moves blocks without stealing CPU data-bus cycles.
module soc_msp430_dmem_dma
    import soc_msp430_dma_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int CNT_W  = DMA_CNT_W
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [CNT_W-1:0]  cfg_cnt,
    input  logic              cfg_fill,
    input  logic [15:0]       cfg_pattern,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  words_left,
    output logic              enb,
    output logic [1:0]        web,
    output logic [ADDR_W-1:0] addrb,
    output logic [15:0]       dinb,
    input  logic [15:0]       doutb
);

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

    dma_state_t        state_r;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [15:0]       pattern_r;
    logic              fill_r;
    logic              busy_r;
    logic              done_r;
    logic              aborted_r;

    logic              enb_s;
    logic [1:0]        web_s;
    logic [ADDR_W-1:0] addrb_s;
    logic [15:0]       dinb_s;

    // Transfer sequencer: state, address/count registers and status flags.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_r   <= ST_IDLE;
            src_r     <= ADDR_ZERO;
            dst_r     <= ADDR_ZERO;
            cnt_r     <= CNT_ZERO;
            pattern_r <= 16'h0000;
            fill_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        src_r     <= cfg_src;
                        dst_r     <= cfg_dst;
                        cnt_r     <= cfg_cnt;
                        pattern_r <= cfg_pattern;
                        fill_r    <= cfg_fill;
                        aborted_r <= 1'b0;
                        if (cfg_cnt == CNT_ZERO) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= cfg_fill ? ST_WRITE : ST_READ;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    src_r <= src_r + ADDR_ONE;
                    if (abort) begin
                        state_r   <= ST_DONE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        aborted_r <= 1'b1;
                    end else begin
                        state_r <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // The write strobed this cycle always lands, even under abort.
                    dst_r <= dst_r + ADDR_ONE;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (abort || (cnt_r == CNT_ONE)) begin
                        state_r   <= ST_DONE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        aborted_r <= abort;
                    end else begin
                        state_r <= fill_r ? ST_WRITE : ST_READ;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Port-B strobe decode; the copy data path passes doutb straight through.
    always_comb begin
        enb_s   = 1'b0;
        web_s   = WE_NONE;
        addrb_s = ADDR_ZERO;
        dinb_s  = 16'h0000;
        case (state_r)
            ST_READ: begin
                enb_s   = 1'b1;
                addrb_s = src_r;
            end
            ST_WRITE: begin
                enb_s   = 1'b1;
                web_s   = WE_WORD;
                addrb_s = dst_r;
                if (fill_r) begin
                    dinb_s = pattern_r;
                end else begin
                    dinb_s = doutb;
                end
            end
            default: begin
                enb_s = 1'b0;
            end
        endcase
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign aborted    = aborted_r;
    assign words_left = cnt_r;
    assign enb        = enb_s;
    assign web        = web_s;
    assign addrb      = addrb_s;
    assign dinb       = dinb_s;

endmodule
